vga_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed 640x480@60 sync block.
- Produces hsync/vsync with configurable per-axis polarity, a visible-area flag, pixel coordinates, line/frame start strobes, and a one-pixel-early visible flag for framebuffer prefetch.
- Sits between the pixel-clock domain and the RAMDAC pixel path. Advances only on a pixel-clock enable.

---
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator; steps one pixel per enabled clock.
// Registered outputs describe the pixel just stepped; visible_next looks one enabled pixel ahead.
module vga_timing_gen #(
  parameter int H_VISIBLE         = 640,
  parameter int H_FRONT           = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BACK            = 48,
  parameter int V_VISIBLE         = 480,
  parameter int V_FRONT           = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BACK            = 33,
  parameter int HSYNC_ACTIVE_HIGH = 0,
  parameter int VSYNC_ACTIVE_HIGH = 0,
  parameter int CNT_W             = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic             visible_next,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W)) ||
      (H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
      (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0)) begin : g_bad_params
    $error("vga_timing_gen: timing parameters out of range");
  end

  localparam logic [CNT_W-1:0] ZERO       = '0;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic             H_ON       = (HSYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
  localparam logic             V_ON       = (VSYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic [CNT_W-1:0] h_next_s;
  logic [CNT_W-1:0] v_next_s;
  logic             hsync_s;
  logic             vsync_s;

  function automatic logic in_active(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    return (h < H_VIS) && (v < V_VIS);
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] beg,
                                     input logic [CNT_W-1:0] fin);
    return (c >= beg) && (c < fin);
  endfunction

  // Raster successor: wrap at line end, and both axes at frame end.
  always_comb begin
    h_next_s = h_cnt_r;
    v_next_s = v_cnt_r;
    if (h_cnt_r == H_LAST) begin
      h_next_s = ZERO;
      if (v_cnt_r == V_LAST) begin
        v_next_s = ZERO;
      end else begin
        v_next_s = v_cnt_r + ONE;
      end
    end else begin
      h_next_s = h_cnt_r + ONE;
    end
  end

  // Sync windows of the current counters, mapped to the configured polarity.
  always_comb begin
    hsync_s = ~H_ON;
    vsync_s = ~V_ON;
    if (in_window(h_cnt_r, H_SYNC_BEG, H_SYNC_END)) begin
      hsync_s = H_ON;
    end else begin
      hsync_s = ~H_ON;
    end
    if (in_window(v_cnt_r, V_SYNC_BEG, V_SYNC_END)) begin
      vsync_s = V_ON;
    end else begin
      vsync_s = ~V_ON;
    end
  end

  // Counters and output registers advance together, only on enabled edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt_r      <= ZERO;
      v_cnt_r      <= ZERO;
      hsync        <= ~H_ON;
      vsync        <= ~V_ON;
      visible      <= 1'b0;
      visible_next <= 1'b1;
      pixel_x      <= ZERO;
      pixel_y      <= ZERO;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else if (enable) begin
      h_cnt_r      <= h_next_s;
      v_cnt_r      <= v_next_s;
      hsync        <= hsync_s;
      vsync        <= vsync_s;
      visible      <= in_active(h_cnt_r, v_cnt_r);
      visible_next <= in_active(h_next_s, v_next_s);
      pixel_x      <= h_cnt_r;
      pixel_y      <= v_cnt_r;
      line_start   <= (h_cnt_r == ZERO);
      frame_start  <= (h_cnt_r == ZERO) && (v_cnt_r == ZERO);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a short-frame variant and a tiny active-high variant.
module tb_vga_timing_gen;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  logic en_d, hs_d, vs_d, vis_d, vn_d, ls_d, fs_d;
  logic [11:0] px_d, py_d;
  logic en_m, hs_m, vs_m, vis_m, vn_m, ls_m, fs_m;
  logic [11:0] px_m, py_m;
  logic en_s, hs_s, vs_s, vis_s, vn_s, ls_s, fs_s;
  logic [11:0] px_s, py_s;

  vga_timing_gen dut_d (
    .clock(clock), .reset(reset), .enable(en_d), .hsync(hs_d), .vsync(vs_d),
    .visible(vis_d), .visible_next(vn_d), .pixel_x(px_d), .pixel_y(py_d),
    .line_start(ls_d), .frame_start(fs_d));

  vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) dut_m (
    .clock(clock), .reset(reset), .enable(en_m), .hsync(hs_m), .vsync(vs_m),
    .visible(vis_m), .visible_next(vn_m), .pixel_x(px_m), .pixel_y(py_m),
    .line_start(ls_m), .frame_start(fs_m));

  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HSYNC_ACTIVE_HIGH(1), .VSYNC_ACTIVE_HIGH(1)) dut_s (
    .clock(clock), .reset(reset), .enable(en_s), .hsync(hs_s), .vsync(vs_s),
    .visible(vis_s), .visible_next(vn_s), .pixel_x(px_s), .pixel_y(py_s),
    .line_start(ls_s), .frame_start(fs_s));

  // {hsync, vsync, visible, visible_next, line_start, frame_start} for the pixel at (x, y)
  function automatic logic [5:0] exp_flags(input int x, input int y,
      input int hv, input int hf, input int hs, input int hb,
      input int vv, input int vf, input int vs, input int vb,
      input logic hpol, input logic vpol);
    logic [5:0] r;
    int nx, ny;
    nx = x + 1;
    ny = y;
    if (nx == hv + hf + hs + hb) begin
      nx = 0;
      ny = (y + 1 == vv + vf + vs + vb) ? 0 : y + 1;
    end
    r[5] = ((x >= hv + hf) && (x < hv + hf + hs)) ? hpol : ~hpol;
    r[4] = ((y >= vv + vf) && (y < vv + vf + vs)) ? vpol : ~vpol;
    r[3] = (x < hv) && (y < vv);
    r[2] = (nx < hv) && (ny < vv);
    r[1] = (x == 0);
    r[0] = (x == 0) && (y == 0);
    return r;
  endfunction

  function automatic logic [29:0] exp_d(input int x, input int y);
    return {exp_flags(x, y, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0), 12'(x), 12'(y)};
  endfunction
  function automatic logic [29:0] exp_m(input int x, input int y);
    return {exp_flags(x, y, 640, 16, 96, 48, 4, 1, 1, 1, 1'b0, 1'b0), 12'(x), 12'(y)};
  endfunction
  function automatic logic [29:0] exp_s(input int x, input int y);
    return {exp_flags(x, y, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1), 12'(x), 12'(y)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    en_d = 1'b0; en_m = 1'b0; en_s = 1'b0;
    #2 reset = 1'b1;
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [29:0] got;
    pulse_reset();
    got = {hs_d, vs_d, vis_d, vn_d, ls_d, fs_d, px_d, py_d};
    checks++;
    if (got !== {6'b110100, 24'd0}) begin
      errors++; $display("FAIL reset_d: got %h expected %h", got, {6'b110100, 24'd0});
    end
    got = {hs_m, vs_m, vis_m, vn_m, ls_m, fs_m, px_m, py_m};
    checks++;
    if (got !== {6'b110100, 24'd0}) begin
      errors++; $display("FAIL reset_m: got %h expected %h", got, {6'b110100, 24'd0});
    end
    got = {hs_s, vs_s, vis_s, vn_s, ls_s, fs_s, px_s, py_s};
    checks++;
    if (got !== {6'b000100, 24'd0}) begin
      errors++; $display("FAIL reset_s: got %h expected %h", got, {6'b000100, 24'd0});
    end
    for (int i = 0; i < 3; i++) tick();
    got = {hs_d, vs_d, vis_d, vn_d, ls_d, fs_d, px_d, py_d};
    checks++;
    if (got !== {6'b110100, 24'd0}) begin
      errors++; $display("FAIL reset_hold_d: got %h expected %h", got, {6'b110100, 24'd0});
    end
  endtask

  task automatic test_default_lines();
    logic [29:0] got, expv;
    logic prev_vn;
    int x, y, hlow, hfirst, vis_cnt;
    x = 0; y = 0; hlow = 0; hfirst = -1; vis_cnt = 0; prev_vn = 1'b0;
    pulse_reset();
    en_d = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      tick();
      got  = {hs_d, vs_d, vis_d, vn_d, ls_d, fs_d, px_d, py_d};
      expv = exp_d(x, y);
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL step_d(%0d,%0d): got %h expected %h", x, y, got, expv);
      end
      if (k > 0) begin
        checks++;
        if (vis_d !== prev_vn) begin
          errors++; $display("FAIL vnext_d(%0d,%0d): visible %b previous visible_next %b", x, y, vis_d, prev_vn);
        end
      end
      prev_vn = vn_d;
      if (y == 0) begin
        if (hs_d == 1'b0) begin
          hlow++;
          if (hfirst < 0) hfirst = int'(px_d);
        end
        if (vis_d == 1'b1) vis_cnt++;
      end
      x++;
      if (x == 800) begin x = 0; y++; end
    end
    en_d = 1'b0;
    checks++;
    if (hlow != 96) begin errors++; $display("FAIL hsync_width: got %0d expected 96", hlow); end
    checks++;
    if (hfirst != 656) begin errors++; $display("FAIL hsync_start: got %0d expected 656", hfirst); end
    checks++;
    if (vis_cnt != 640) begin errors++; $display("FAIL visible_run: got %0d expected 640", vis_cnt); end
  endtask

  task automatic test_vsync_frame();
    logic [29:0] got, expv;
    logic prev_vs;
    int x, y, fs_cnt, vlow;
    x = 0; y = 0; fs_cnt = 0; vlow = 0; prev_vs = 1'b1;
    pulse_reset();
    en_m = 1'b1;
    for (int k = 0; k <= 5600; k++) begin
      tick();
      got  = {hs_m, vs_m, vis_m, vn_m, ls_m, fs_m, px_m, py_m};
      expv = exp_m(x, y);
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL step_m(%0d,%0d): got %h expected %h", x, y, got, expv);
      end
      if (vs_m !== prev_vs) begin
        checks++;
        if (px_m !== 12'd0) begin
          errors++; $display("FAIL vsync_edge: edge at pixel_x %0d expected 0", px_m);
        end
      end
      prev_vs = vs_m;
      if (k < 5600) begin
        if (fs_m == 1'b1) fs_cnt++;
        if (vs_m == 1'b0) vlow++;
      end
      x++;
      if (x == 800) begin x = 0; y = (y == 6) ? 0 : y + 1; end
    end
    en_m = 1'b0;
    checks++;
    if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count_m: got %0d expected 1", fs_cnt); end
    checks++;
    if (vlow != 800) begin errors++; $display("FAIL vsync_width_m: got %0d expected 800", vlow); end
  endtask

  task automatic test_small_polarity();
    logic [29:0] got, expv;
    int x, y, fs_cnt, hhi, vhi;
    x = 0; y = 0; fs_cnt = 0; hhi = 0; vhi = 0;
    pulse_reset();
    en_s = 1'b1;
    for (int k = 0; k <= 196; k++) begin
      tick();
      got  = {hs_s, vs_s, vis_s, vn_s, ls_s, fs_s, px_s, py_s};
      expv = exp_s(x, y);
      checks++;
      if (got !== expv) begin
        errors++; $display("FAIL step_s(%0d,%0d): got %h expected %h", x, y, got, expv);
      end
      if (k < 98) begin
        if (fs_s == 1'b1) fs_cnt++;
        if (hs_s == 1'b1) hhi++;
        if (vs_s == 1'b1) vhi++;
      end
      x++;
      if (x == 14) begin x = 0; y = (y == 6) ? 0 : y + 1; end
    end
    en_s = 1'b0;
    checks++;
    if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count_s: got %0d expected 1", fs_cnt); end
    checks++;
    if (hhi != 14) begin errors++; $display("FAIL hsync_high_s: got %0d expected 14", hhi); end
    checks++;
    if (vhi != 14) begin errors++; $display("FAIL vsync_high_s: got %0d expected 14", vhi); end
  endtask

  task automatic test_random_enable();
    logic [29:0] got, last_exp;
    logic prev_vn;
    int x, y, n, last_x, hold_run;
    x = 0; y = 0; n = 0; last_x = -1; hold_run = 0; prev_vn = 1'b1;
    pulse_reset();
    last_exp = {6'b110100, 24'd0};
    for (int c = 0; c < 40000 && n < 11201; c++) begin
      if (last_x == 799 && hold_run < 4) begin
        en_m = 1'b0;
        hold_run++;
      end else begin
        en_m = ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0;
      end
      tick();
      if (en_m == 1'b1) begin
        last_exp = exp_m(x, y);
        last_x = x;
        hold_run = 0;
        n++;
        checks++;
        if (vis_m !== prev_vn) begin
          errors++; $display("FAIL vnext_m(%0d,%0d): visible %b previous visible_next %b", x, y, vis_m, prev_vn);
        end
        prev_vn = vn_m;
        x++;
        if (x == 800) begin x = 0; y = (y == 6) ? 0 : y + 1; end
      end
      got = {hs_m, vs_m, vis_m, vn_m, ls_m, fs_m, px_m, py_m};
      checks++;
      if (got !== last_exp) begin
        errors++; $display("FAIL rand_m cycle %0d en %b: got %h expected %h", c, en_m, got, last_exp);
      end
    end
    en_m = 1'b0;
    checks++;
    if (n != 11201) begin errors++; $display("FAIL rand_budget: got %0d steps expected 11201", n); end
  endtask

  task automatic test_reset_mid();
    logic [29:0] got, expv;
    pulse_reset();
    en_d = 1'b1;
    for (int k = 0; k < 1901; k++) tick();
    checks++;
    if ({px_d, py_d} !== {12'd300, 12'd2}) begin
      errors++; $display("FAIL mid_position: got (%0d,%0d) expected (300,2)", px_d, py_d);
    end
    #2 reset = 1'b1;
    #1;
    got = {hs_d, vs_d, vis_d, vn_d, ls_d, fs_d, px_d, py_d};
    checks++;
    if (got !== {6'b110100, 24'd0}) begin
      errors++; $display("FAIL async_reset: got %h expected %h", got, {6'b110100, 24'd0});
    end
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b0;
    tick();
    got  = {hs_d, vs_d, vis_d, vn_d, ls_d, fs_d, px_d, py_d};
    expv = {6'b111111, 24'd0};
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL first_after_reset: got %h expected %h", got, expv);
    end
    tick();
    got  = {hs_d, vs_d, vis_d, vn_d, ls_d, fs_d, px_d, py_d};
    expv = exp_d(1, 0);
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL second_after_reset: got %h expected %h", got, expv);
    end
    en_d = 1'b0;
  endtask

  initial begin
    en_d = 1'b0; en_m = 1'b0; en_s = 1'b0;
    test_reset();
    test_default_lines();
    test_vsync_frame();
    test_small_polarity();
    test_random_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
